jhash_core: RTL and testbench
=============================

Name: jhash_core

Overview:
- Consumer end of the jhash stream interface. Accepts 3x32-bit key blocks from the input stage (stream_data0..2 with valid/ack), plus a final tail beat flagged by stream_done/stream_left.
- Runs the Jenkins lookup2 word hash (jhash2 semantics) over the message and returns a 32-bit hash with a valid/ack handshake.
- Sits between the input stage and the hash consumer (bucket/lookup logic) in the compressor match path.

Parameters:
- GOLDEN, 32'h9e3779b9, initial value for a and b.
- CNT_W, 32, width of the message word counter; wraps mod 2^CNT_W.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset. Asynchronous, active-high.
- initval  input  32  hash seed, sampled on the first accepted beat of a message.
- stream_data0  input  32  key word k0.
- stream_data1  input  32  key word k1.
- stream_data2  input  32  key word k2.
- stream_valid  input  1  beat present.
- stream_done  input  1  current beat is the final beat of the message.
- stream_left  input  2  valid words in the final beat, 0..3; ignored when stream_done=0.
- stream_ack  output  1  core accepts the beat. Transfer occurs when stream_valid && stream_ack.
- hash_out  output  32  final hash (register c).
- hash_valid  output  1  hash_out is valid; held until accepted.
- hash_ack  input  1  downstream accepts hash; transfer when hash_valid && hash_ack.

Behaviour:
- Reset: state=S_IDLE, a=b=GOLDEN, c=0, word count=0, first=1, hash_out=0, hash_valid=0. stream_ack=1 after reset; it is a decode of state (1 only in S_IDLE).
- Mix is the 3 rows of __jhash_mix, one row per cycle. Each row is a sequential chain on a, b, c in that order:
  - row0 shifts: a^=c>>13, b^=a<<8, c^=b>>13.
  - row1 shifts: a^=c>>12, b^=a<<16, c^=b>>5.
  - row2 shifts: a^=c>>3, b^=a<<10, c^=b>>15.
  - Each step is x-=y; x-=z; x^=shift. All arithmetic is mod 2^32.
- On the first beat of a message, a and b are loaded with GOLDEN and c with initval before the add.
- S_IDLE, accepted beat with done=0: a+=k0, b+=k1, c+=k2; count+=3 -> S_MIX.
- S_IDLE, accepted beat with done=1 and left=3: add as a full block, count+=3 -> S_MIX with fin_pending=1.
- S_IDLE, accepted beat with done=1 and left<=2:
  - count+=left.
  - c+=4*(new count).
  - left>=2: b+=k1. left>=1: a+=k0.
  - -> S_FMIX.
- S_MIX: 3 cycles (row counter 0..2).
  - fin_pending=0: -> S_IDLE.
  - fin_pending=1: -> S_FIN.
- S_FIN: 1 cycle, c+=4*count -> S_FMIX.
- S_FMIX: 3 cycles -> S_OUT.
  - Load hash_out=c (post-row2 value) and set hash_valid=1 on the transition.
- S_OUT: hold until hash_ack.
  - On ack: hash_valid=0, first=1, count=0 -> S_IDLE.
  - hash_ack is ignored while hash_valid=0.
- Latency:
  - Full block: ack re-asserts 4 cycles after acceptance.
  - Done beat with left<=2: hash_valid rises 4 cycles after acceptance.
  - Done beat with left=3: hash_valid rises 8 cycles after acceptance.
- Empty message (first beat done=1, left=0): c=initval+0, then final mix. Result equals jhash2(k,0,initval).
- stream_valid=0 in S_IDLE: no state change.
- Beat data is never consumed outside S_IDLE.
- Reset asserted mid-message or mid-output: immediate return to reset values, and the partial message is discarded.

Decomposition:
- Shared package jhash_pkg holds:
  - GOLDEN.
  - Mix shift constants (13,8,13 / 12,16,5 / 3,10,15).
  - The state encoding S_IDLE, S_MIX, S_FIN, S_FMIX, S_OUT.
- One natural sub-module, jhash_mix_row: purely combinational. Inputs a, b, c and 2-bit row select; outputs the next a, b, c. Instantiated once and shared by S_MIX and S_FMIX.

Test Plan:
- Empty message, initval=0: one beat with done=1, left=0 -> ack low for 4 cycles, hash_valid 4 cycles after accept. hash_out equals C model jhash2(NULL,0,0).
- Single full block k=(1,2,3), then done beat left=0, initval=0x12345678:
  - Ack pattern 1,0,0,0,1.
  - hash_out equals jhash2({1,2,3},3,0x12345678).
- Four-word message {0xdeadbeef,0,0xffffffff,0x80000000}: block, then done beat left=1 -> exercises a/b/c wraparound. Hash equals the C model result; c length term = 16.
- Done beat with left=3, k=(0xa,0xb,0xc): hash_valid 8 cycles after accept; equals jhash2(k,3,initval).
- Backpressure, hash_ack held low 10 cycles:
  - hash_valid and hash_out stable throughout.
  - stream_ack=0 throughout, and a new stream_valid is not consumed.
  - After ack, the next message hashes with fresh GOLDEN/initval.
- Reset asserted in S_MIX cycle 2 -> outputs return to reset values asynchronously. A following 3-word message produces the correct model hash.

Source files
------------

// File: rtl/jhash_pkg.sv
// jhash_pkg: shared constants, state encoding and mix shift table for the jhash core
package jhash_pkg;

    localparam logic [31:0] GOLDEN = 32'h9e3779b9;
    localparam int          CNT_W  = 32;

    localparam logic [4:0] SH_A0 = 5'd13, SH_B0 = 5'd8,  SH_C0 = 5'd13;
    localparam logic [4:0] SH_A1 = 5'd12, SH_B1 = 5'd16, SH_C1 = 5'd5;
    localparam logic [4:0] SH_A2 = 5'd3,  SH_B2 = 5'd10, SH_C2 = 5'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MIX,
        S_FIN,
        S_FMIX,
        S_OUT
    } state_t;

    typedef struct packed {
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] sc;
    } shifts_t;

    // Shift amounts for one row of the mix; row 3 never occurs and aliases row 2.
    function automatic shifts_t row_shifts(input logic [1:0] row);
        return (row == 2'd0) ? {SH_A0, SH_B0, SH_C0} :
               (row == 2'd1) ? {SH_A1, SH_B1, SH_C1} :
                               {SH_A2, SH_B2, SH_C2};
    endfunction

endpackage

// File: rtl/jhash_mix_row.sv
// jhash_mix_row: one combinational row of the lookup2 mix (a, b, c chained in order)
module jhash_mix_row
    import jhash_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_c,
    input  logic [1:0]  i_row,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    output logic [31:0] o_c
);

    shifts_t     w_sh;
    logic [31:0] w_a;
    logic [31:0] w_b;

    assign w_sh = row_shifts(i_row);
    assign w_a  = (i_a - i_b - i_c) ^ (i_c >> w_sh.sa);
    assign w_b  = (i_b - i_c - w_a) ^ (w_a << w_sh.sb);
    assign o_c  = (i_c - w_a - w_b) ^ (w_b >> w_sh.sc);
    assign o_a  = w_a;
    assign o_b  = w_b;

endmodule

// File: rtl/jhash_core.sv
// jhash_core: streaming Jenkins lookup2 (jhash2) word hash with valid/ack in and out
module jhash_core
    import jhash_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] initval,
    input  logic [31:0] stream_data0,
    input  logic [31:0] stream_data1,
    input  logic [31:0] stream_data2,
    input  logic        stream_valid,
    input  logic        stream_done,
    input  logic [1:0]  stream_left,
    output logic        stream_ack,
    output logic [31:0] hash_out,
    output logic        hash_valid,
    input  logic        hash_ack
);

    state_t             r_state;
    state_t             w_state_n;
    logic [31:0]        r_a, r_b, r_c, r_hash;
    logic [31:0]        w_a_n, w_b_n, w_c_n, w_hash_n;
    logic [CNT_W-1:0]   r_cnt, w_cnt_n;
    logic               r_first, r_fin, r_hvalid;
    logic               w_first_n, w_fin_n, w_hvalid_n;
    logic [1:0]         r_row, w_row_n;

    logic               w_acc;
    logic               w_full;
    logic [31:0]        w_ba, w_bb, w_bc;
    logic [CNT_W-1:0]   w_cnt_sum;
    logic [31:0]        w_ma, w_mb, w_mc;

    assign stream_ack = (r_state == S_IDLE);
    assign hash_out   = r_hash;
    assign hash_valid = r_hvalid;

    // A message's first beat starts from the seed values rather than the running state.
    assign w_acc     = stream_valid && (r_state == S_IDLE);
    assign w_full    = !stream_done || (stream_left == 2'd3);
    assign w_ba      = r_first ? GOLDEN  : r_a;
    assign w_bb      = r_first ? GOLDEN  : r_b;
    assign w_bc      = r_first ? initval : r_c;
    assign w_cnt_sum = r_cnt + CNT_W'(w_full ? 2'd3 : stream_left);

    jhash_mix_row u_mix (
        .i_a   (r_a),
        .i_b   (r_b),
        .i_c   (r_c),
        .i_row (r_row),
        .o_a   (w_ma),
        .o_b   (w_mb),
        .o_c   (w_mc)
    );

    // Next-state and datapath decode: absorb beats in IDLE, step the mix, finalise and hand off.
    always_comb begin
        w_state_n  = r_state;
        w_a_n      = r_a;
        w_b_n      = r_b;
        w_c_n      = r_c;
        w_cnt_n    = r_cnt;
        w_first_n  = r_first;
        w_fin_n    = r_fin;
        w_row_n    = r_row;
        w_hash_n   = r_hash;
        w_hvalid_n = r_hvalid;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    w_first_n = 1'b0;
                    w_row_n   = 2'd0;
                    w_cnt_n   = w_cnt_sum;
                    if (w_full) begin
                        w_a_n     = w_ba + stream_data0;
                        w_b_n     = w_bb + stream_data1;
                        w_c_n     = w_bc + stream_data2;
                        w_fin_n   = stream_done;
                        w_state_n = S_MIX;
                    end else begin
                        w_a_n     = w_ba + ((stream_left >= 2'd1) ? stream_data0 : 32'd0);
                        w_b_n     = w_bb + ((stream_left >= 2'd2) ? stream_data1 : 32'd0);
                        w_c_n     = w_bc + (32'(w_cnt_sum) << 2);
                        w_state_n = S_FMIX;
                    end
                end
            end
            S_MIX: begin
                w_a_n   = w_ma;
                w_b_n   = w_mb;
                w_c_n   = w_mc;
                w_row_n = r_row + 2'd1;
                if (r_row == 2'd2) begin
                    w_row_n   = 2'd0;
                    w_state_n = r_fin ? S_FIN : S_IDLE;
                end
            end
            S_FIN: begin
                w_c_n     = r_c + (32'(r_cnt) << 2);
                w_fin_n   = 1'b0;
                w_row_n   = 2'd0;
                w_state_n = S_FMIX;
            end
            S_FMIX: begin
                w_a_n   = w_ma;
                w_b_n   = w_mb;
                w_c_n   = w_mc;
                w_row_n = r_row + 2'd1;
                if (r_row == 2'd2) begin
                    w_row_n    = 2'd0;
                    w_hash_n   = w_mc;
                    w_hvalid_n = 1'b1;
                    w_state_n  = S_OUT;
                end
            end
            S_OUT: begin
                if (hash_ack && r_hvalid) begin
                    w_hvalid_n = 1'b0;
                    w_first_n  = 1'b1;
                    w_cnt_n    = '0;
                    w_state_n  = S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_n;
    end

    // Hash working registers, counters and output holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= GOLDEN;
            r_b      <= GOLDEN;
            r_c      <= '0;
            r_cnt    <= '0;
            r_first  <= 1'b1;
            r_fin    <= 1'b0;
            r_row    <= 2'd0;
            r_hash   <= '0;
            r_hvalid <= 1'b0;
        end else begin
            r_a      <= w_a_n;
            r_b      <= w_b_n;
            r_c      <= w_c_n;
            r_cnt    <= w_cnt_n;
            r_first  <= w_first_n;
            r_fin    <= w_fin_n;
            r_row    <= w_row_n;
            r_hash   <= w_hash_n;
            r_hvalid <= w_hvalid_n;
        end
    end

endmodule

// File: tb/tb_jhash_core.sv
// tb_jhash_core: table-driven, hand-written and random checks of jhash_core against a jhash2 model
module tb_jhash_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] initval = '0;
    logic [31:0] stream_data0 = '0, stream_data1 = '0, stream_data2 = '0;
    logic        stream_valid = 1'b0, stream_done = 1'b0;
    logic [1:0]  stream_left = 2'd0;
    logic        stream_ack;
    logic [31:0] hash_out;
    logic        hash_valid;
    logic        hash_ack = 1'b0;

    int n_pass = 0;
    int n_tot  = 0;

    jhash_core dut (
        .clk          (clk),
        .rst          (rst),
        .initval      (initval),
        .stream_data0 (stream_data0),
        .stream_data1 (stream_data1),
        .stream_data2 (stream_data2),
        .stream_valid (stream_valid),
        .stream_done  (stream_done),
        .stream_left  (stream_left),
        .stream_ack   (stream_ack),
        .hash_out     (hash_out),
        .hash_valid   (hash_valid),
        .hash_ack     (hash_ack)
    );

    always #5 clk = ~clk;

    typedef logic [11:0][31:0] words_t;

    typedef struct packed {
        words_t      k;
        int          len;
        bit          l3;
        logic [31:0] iv;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    function automatic logic [95:0] mix(input logic [31:0] a, b, c);
        a = a - b; a = a - c; a = a ^ (c >> 13);
        b = b - c; b = b - a; b = b ^ (a << 8);
        c = c - a; c = c - b; c = c ^ (b >> 13);
        a = a - b; a = a - c; a = a ^ (c >> 12);
        b = b - c; b = b - a; b = b ^ (a << 16);
        c = c - a; c = c - b; c = c ^ (b >> 5);
        a = a - b; a = a - c; a = a ^ (c >> 3);
        b = b - c; b = b - a; b = b ^ (a << 10);
        c = c - a; c = c - b; c = c ^ (b >> 15);
        return {a, b, c};
    endfunction

    function automatic logic [31:0] jhash2_model(input words_t k, input int len, input logic [31:0] iv);
        logic [31:0] a, b, c;
        int i, l;
        a = 32'h9e3779b9; b = 32'h9e3779b9; c = iv;
        i = 0; l = len;
        while (l >= 3) begin
            a += k[i]; b += k[i+1]; c += k[i+2];
            {a, b, c} = mix(a, b, c);
            i += 3; l -= 3;
        end
        c += 32'(len * 4);
        if (l >= 2) b += k[i+1];
        if (l >= 1) a += k[i];
        {a, b, c} = mix(a, b, c);
        return c;
    endfunction

    function automatic vec_t mk(input words_t k, input int len, input bit l3, input logic [31:0] iv);
        vec_t v;
        v.k = k; v.len = len; v.l3 = l3; v.iv = iv;
        v.exp = jhash2_model(k, len, iv);
        v.lat = (len > 0 && len % 3 == 0 && l3) ? 8 : 4;
        return v;
    endfunction

    function automatic words_t rnd_words();
        words_t k;
        for (int i = 0; i < 12; i++) k[i] = $urandom;
        return k;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic beat(input logic [31:0] k0, k1, k2, input logic done, input logic [1:0] left);
        int n;
        stream_data0 = k0; stream_data1 = k1; stream_data2 = k2;
        stream_done = done; stream_left = left; stream_valid = 1'b1;
        n = 0;
        while (!stream_ack && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!stream_ack) check("beat_ack_timeout", 32'(stream_ack), 32'd1);
        @(negedge clk);
        stream_valid = 1'b0; stream_done = 1'b0;
    endtask

    task automatic send_msg(input words_t k, input int len, input bit l3, input logic [31:0] iv);
        int i, l;
        i = 0; l = len;
        initval = iv;
        while (l > 3 || (l == 3 && !l3)) begin
            beat(k[i], k[i+1], k[i+2], 1'b0, 2'd0);
            initval = $urandom;
            i += 3; l -= 3;
        end
        beat(l >= 1 ? k[i] : $urandom, l >= 2 ? k[i+1] : $urandom, l == 3 ? k[i+2] : $urandom, 1'b1, 2'(l));
        initval = $urandom;
    endtask

    task automatic wait_hash(output logic [31:0] h, output int lat, output bit ack_hi);
        lat = 1; ack_hi = 1'b0;
        while (!hash_valid && lat < 100) begin
            ack_hi |= stream_ack;
            @(negedge clk);
            lat++;
        end
        ack_hi |= stream_ack;
        check("hash_valid_rise", 32'(hash_valid), 32'd1);
        h = hash_out;
    endtask

    task automatic release_hash();
        hash_ack = 1'b1;
        @(negedge clk);
        hash_ack = 1'b0;
        check("hash_valid_drop", 32'(hash_valid), 32'd0);
    endtask

    vec_t        tbl[6];
    words_t      kk;
    logic [31:0] h, iv;
    int          lat, len;
    bit          ack_hi, l3;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_stream_ack", 32'(stream_ack), 32'd1);
        check("rst_hash_valid", 32'(hash_valid), 32'd0);
        check("rst_hash_out", hash_out, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Empty message, seed 0: ack low the whole time, result after 4 cycles.
        initval = 32'd0;
        beat($urandom, $urandom, $urandom, 1'b1, 2'd0);
        wait_hash(h, lat, ack_hi);
        check("empty_hash", h, jhash2_model('0, 0, 32'd0));
        check("empty_lat", 32'(lat), 32'd4);
        check("empty_ack_low", 32'(ack_hi), 32'd0);
        release_hash();

        // Single block then empty done beat: ack pattern 1,0,0,0,1.
        initval = 32'h12345678;
        beat(32'd1, 32'd2, 32'd3, 1'b0, 2'd0);
        initval = $urandom;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("blk_ack_c%0d", i), 32'(stream_ack), (i == 4) ? 32'd1 : 32'd0);
            if (i < 4) @(negedge clk);
        end
        beat($urandom, $urandom, $urandom, 1'b1, 2'd0);
        wait_hash(h, lat, ack_hi);
        kk = '0; kk[0] = 32'd1; kk[1] = 32'd2; kk[2] = 32'd3;
        check("blk_hash", h, jhash2_model(kk, 3, 32'h12345678));
        check("blk_lat", 32'(lat), 32'd4);
        release_hash();

        // Table of fixed messages.
        kk = rnd_words(); kk[0] = 32'hdeadbeef; kk[1] = 32'd0; kk[2] = 32'hffffffff; kk[3] = 32'h80000000;
        tbl[0] = mk(kk, 4, 1'b0, 32'd0);
        kk = rnd_words(); kk[0] = 32'ha; kk[1] = 32'hb; kk[2] = 32'hc;
        tbl[1] = mk(kk, 3, 1'b1, 32'hcafef00d);
        kk = rnd_words(); kk[0] = 32'h11111111; kk[1] = 32'h22222222;
        tbl[2] = mk(kk, 2, 1'b0, 32'd5);
        tbl[3] = mk(rnd_words(), 6, 1'b1, $urandom);
        tbl[4] = mk(rnd_words(), 9, 1'b0, 32'hffffffff);
        tbl[5] = mk(rnd_words(), 7, 1'b0, $urandom);
        for (int t = 0; t < 6; t++) begin
            send_msg(tbl[t].k, tbl[t].len, tbl[t].l3, tbl[t].iv);
            wait_hash(h, lat, ack_hi);
            check($sformatf("tbl%0d_hash", t), h, tbl[t].exp);
            check($sformatf("tbl%0d_lat", t), 32'(lat), 32'(tbl[t].lat));
            release_hash();
        end

        // Backpressure: output held, no beats consumed, next message starts fresh.
        kk = rnd_words();
        send_msg(kk, 5, 1'b0, 32'h0badf00d);
        wait_hash(h, lat, ack_hi);
        check("bp_hash", h, jhash2_model(kk, 5, 32'h0badf00d));
        stream_data0 = $urandom; stream_data1 = $urandom; stream_data2 = $urandom;
        stream_done = 1'b1; stream_left = 2'd1; stream_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("bp_valid_%0d", i), 32'(hash_valid), 32'd1);
            check($sformatf("bp_out_%0d", i), hash_out, h);
            check($sformatf("bp_sack_%0d", i), 32'(stream_ack), 32'd0);
        end
        hash_ack = 1'b1;
        @(negedge clk);
        hash_ack = 1'b0; stream_valid = 1'b0; stream_done = 1'b0;
        check("bp_valid_drop", 32'(hash_valid), 32'd0);
        kk = rnd_words();
        send_msg(kk, 4, 1'b0, 32'h13579bdf);
        wait_hash(h, lat, ack_hi);
        check("bp_next_hash", h, jhash2_model(kk, 4, 32'h13579bdf));
        release_hash();

        // Reset in the second mix cycle discards the partial message.
        initval = $urandom;
        beat($urandom, $urandom, $urandom, 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_stream_ack", 32'(stream_ack), 32'd1);
        check("mrst_hash_valid", 32'(hash_valid), 32'd0);
        check("mrst_hash_out", hash_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        kk = rnd_words();
        send_msg(kk, 3, 1'b0, 32'h2468ace0);
        wait_hash(h, lat, ack_hi);
        check("mrst_next_hash", h, jhash2_model(kk, 3, 32'h2468ace0));
        release_hash();

        // Random messages with random downstream delay.
        for (int r = 0; r < 20; r++) begin
            kk  = rnd_words();
            len = $urandom_range(0, 9);
            l3  = (len > 0 && len % 3 == 0) ? bit'($urandom_range(0, 1)) : 1'b0;
            iv  = $urandom;
            send_msg(kk, len, l3, iv);
            wait_hash(h, lat, ack_hi);
            check($sformatf("rnd%0d_hash", r), h, jhash2_model(kk, len, iv));
            check($sformatf("rnd%0d_lat", r), 32'(lat), (len > 0 && len % 3 == 0 && l3) ? 32'd8 : 32'd4);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check($sformatf("rnd%0d_hold", r), hash_out, h);
            release_hash();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
